// File: rtl/aes_mixcol_seq.sv
// Column-serial AES MixColumns / InvMixColumns engine.
// One 32-bit column per clock, valid/ready on both sides.

module gf256mult (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] acc;
    logic [7:0] x;

    always_comb begin
        acc = 8'h00;
        x   = a_i;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) acc = acc ^ x;
            // xtime with reduction by x^8+x^4+x^3+x+1
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        p_o = acc;
    end
endmodule

module aes_mixcol_seq #(
    parameter bit SUPPORT_INV = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam logic [31:0] FWD = 32'h02030101;
    localparam logic [31:0] INV = 32'h0e0b0d09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;
    logic         inv_q, inv_d;
    logic [1:0]   col_q, col_d;

    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [7:0]   a    [4];
    logic [7:0]   prod [4][4];
    logic         use_inv;
    logic         accept;

    assign use_inv = SUPPORT_INV & inv_q;

    always_comb begin
        col_in = 32'h0;
        unique case (col_q)
            2'd0: col_in = src_q[127:96];
            2'd1: col_in = src_q[95:64];
            2'd2: col_in = src_q[63:32];
            2'd3: col_in = src_q[31:0];
        endcase
    end

    // Coefficient for row r, input byte j is row0[(j - r) mod 4]
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign a[r] = col_in[31-8*r -: 8];
        for (genvar j = 0; j < 4; j++) begin : g_term
            localparam int K = (j - r + 4) % 4;
            logic [7:0] cf;
            if (SUPPORT_INV) begin : g_inv
                assign cf = use_inv ? INV[31-8*K -: 8] : FWD[31-8*K -: 8];
            end else begin : g_fwd
                assign cf = FWD[31-8*K -: 8];
            end
            gf256mult u_mul (
                .a_i (a[j]),
                .b_i (cf),
                .p_o (prod[r][j])
            );
        end
        assign col_out[31-8*r -: 8] =
            prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
    end

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_data  = res_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        inv_d   = inv_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d   = in_data;
                    inv_d   = SUPPORT_INV & in_inv;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                unique case (col_q)
                    2'd0: res_d[127:96] = col_out;
                    2'd1: res_d[95:64]  = col_out;
                    2'd2: res_d[63:32]  = col_out;
                    2'd3: res_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        src_d   = in_data;
                        inv_d   = SUPPORT_INV & in_inv;
                        col_d   = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
            col_q   <= col_d;
        end
    end
endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Scoreboard bench for aes_mixcol_seq against a matrix-level
// GF(2^8) MixColumns reference model.

module tb_aes_mixcol_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    logic         f_in_valid = 1'b0;
    logic         f_in_ready;
    logic [127:0] f_in_data = '0;
    logic         f_in_inv = 1'b0;
    logic         f_out_valid;
    logic         f_out_ready = 1'b1;
    logic [127:0] f_out_data;
    logic         f_busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    aes_mixcol_seq #(.SUPPORT_INV(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    aes_mixcol_seq #(.SUPPORT_INV(1'b0)) dut_f (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .in_data   (f_in_data),
        .in_inv    (f_in_inv),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .out_data  (f_out_data),
        .busy      (f_busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] mixref(input logic [127:0] s, input logic inv);
        logic [7:0]   row0 [4];
        logic [127:0] res;
        logic [7:0]   acc;
        if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(row0[(j - r + 4) % 4], s[127-8*(4*c+j) -: 8]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake consumes one scoreboard entry
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                chk("scoreboard", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp);
        bit ok;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 128'(ok), 128'd1);
        else exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s, m;
        logic         inv;
        bit           seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'h0);

        // Forward directed vector plus latency
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            chk("busy_during_cols", 128'(busy), 128'd1);
        end
        chk("latency_early", 128'(seen), 128'd0);
        @(negedge clk);
        chk("latency_valid", 128'(out_valid), 128'd1);
        drain();

        // Inverse directed vector
        s = 128'h8e4da1bc_9fdc589d_d4d4d4d5_4d7ebdf8;
        send(s, 1'b1, mixref(s, 1'b1));
        drain();
        m = mixref(s, 1'b1);
        chk("inv_col0", 128'(m[127:64]), 128'hdb135345_f20a225c);
        chk("inv_col3", 128'(m[31:0]), 128'h2d26314c);

        // Backpressure, then same-edge handoff
        @(posedge clk);
        #1 out_ready = 1'b0;
        send({4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_reach_done", 128'(seen), 128'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_data", out_data, {4{32'h8e4da1bc}});
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = {4{32'hd4d4d4d5}};
        in_inv    = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({4{32'hd5d5d7d6}});
        @(negedge clk);
        chk("handoff_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("handoff_busy", 128'(busy), 128'd1);
        chk("handoff_valid_drop", 128'(out_valid), 128'd0);
        drain();

        // Mid-operation reset at E2
        send({4{32'h01234567}}, 1'b0, 128'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 128'(out_valid), 128'd0);
        chk("midrst_data", out_data, 128'h0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_busy", 128'(busy), 128'd0);
        send({4{32'h2d26314c}}, 1'b0, {4{32'h4d7ebdf8}});
        drain();

        // in_valid / in_inv wiggling while busy
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, mixref(s, 1'b0));
        for (int k = 0; k < 3; k++) begin
            in_valid = ~in_valid;
            in_inv   = ~in_inv;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Random back-to-back with round trips
        for (int n = 0; n < 24; n++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            send(s, inv, mixref(s, inv));
            send(mixref(s, 1'b0), 1'b1, s);
        end
        drain();

        // Forward-only build ignores in_inv
        @(posedge clk);
        #1;
        f_in_valid = 1'b1;
        f_in_inv   = 1'b1;
        f_in_data  = {4{32'hdb135345}};
        @(negedge clk);
        chk("f_in_ready", 128'(f_in_ready), 128'd1);
        @(posedge clk);
        #1 f_in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (f_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("f_valid", 128'(seen), 128'd1);
        chk("f_data", f_out_data, {4{32'h8e4da1bc}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
